// File: rtl/rf_bypass_sb_if.sv
// Port bundle for the bypassed register file: two read ports, two write ports,
// destination issue, scoreboard flush and busy count.
interface rf_bypass_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rbusy1;
    logic            rbusy2;

    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;

    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic [AW:0]     busy_cnt;

    modport master (
        output ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_rd, flush,
        input  rd1, rd2, rbusy1, rbusy2, busy_cnt
    );

    modport slave (
        input  ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_rd, flush,
        output rd1, rd2, rbusy1, rbusy2, busy_cnt
    );
endinterface

// File: rtl/rf_bypass_sb.sv
// 2-write/2-read register file with same-cycle write bypass and a per-register
// busy scoreboard for the decode hazard logic.
module rf_bypass_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    rf_bypass_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] rf_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     busy_cnt_reg;
    logic [AW:0]     busy_cnt_next;

    logic            w0_ok;
    logic            w1_ok;
    logic            iss_ok;
    logic [NREG-1:0] wsel0;
    logic [NREG-1:0] wsel1;
    logic [NREG-1:0] iss_sel;
    logic [AW-1:0]   ra [2];

    // Out-of-range addresses and the hardwired zero register are never stored or tracked.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREG) && !(ZERO_REG && (a == '0));
    endfunction

    // Requests are gated by reset so a held-low reset also suppresses bypass.
    assign w0_ok  = rst && bus.we0    && addr_ok(bus.wa0);
    assign w1_ok  = rst && bus.we1    && addr_ok(bus.wa1);
    assign iss_ok = rst && bus.iss_en && addr_ok(bus.iss_rd);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            assign wsel0[gi]   = w0_ok  && (int'(bus.wa0)    == gi);
            assign wsel1[gi]   = w1_ok  && (int'(bus.wa1)    == gi);
            assign iss_sel[gi] = iss_ok && (int'(bus.iss_rd) == gi);
            // Flush beats a new producer, which beats a completing write.
            assign busy_next[gi] = bus.flush                ? 1'b0 :
                                   iss_sel[gi]              ? 1'b1 :
                                   (wsel0[gi] | wsel1[gi])  ? 1'b0 :
                                                              busy_reg[gi];
        end
    endgenerate

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_next = busy_cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wsel1[i]) begin
                    rf_reg[i] <= bus.wd1;
                end else if (wsel0[i]) begin
                    rf_reg[i] <= bus.wd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            logic            hit0;
            logic            hit1;
            logic [XLEN-1:0] rd_val;
            logic            rbusy_val;

            always_comb begin
                hit0      = w0_ok && (bus.wa0 == ra[gi]);
                hit1      = w1_ok && (bus.wa1 == ra[gi]);
                rd_val    = '0;
                rbusy_val = 1'b0;
                if (addr_ok(ra[gi])) begin
                    if (hit1) begin
                        rd_val = bus.wd1;
                    end else if (hit0) begin
                        rd_val = bus.wd0;
                    end else begin
                        rd_val = rf_reg[ra[gi]];
                    end
                    // A completing write clears busy now; a same-cycle issue does not set it.
                    rbusy_val = busy_reg[ra[gi]] && !(hit0 || hit1);
                end
            end
        end
    endgenerate

    assign bus.rd1      = g_read[0].rd_val;
    assign bus.rd2      = g_read[1].rd_val;
    assign bus.rbusy1   = g_read[0].rbusy_val;
    assign bus.rbusy2   = g_read[1].rbusy_val;
    assign bus.busy_cnt = busy_cnt_reg;
endmodule

// File: tb/tb_rf_bypass_sb.sv
// Bench for rf_bypass_sb: directed scenarios on a 32-entry and a 24-entry
// instance, then randomized traffic against an array-based reference model.
module tb_rf_bypass_sb;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int NREG_B = 24;
    localparam int AW_B   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    rf_bypass_sb_if #(.XLEN(32), .AW(AW))   a ();
    rf_bypass_sb_if #(.XLEN(32), .AW(AW_B)) b ();

    rf_bypass_sb #(.XLEN(32), .NREG(NREG), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    rf_bypass_sb #(.XLEN(32), .NREG(NREG_B), .ZERO_REG(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents and busy set of the 32-entry instance.
    logic [31:0] m_rf   [NREG];
    bit          m_busy [NREG];

    function automatic bit m_null(input int ad);
        return (ad >= NREG) || (ad == 0);
    endfunction

    function automatic bit m_writes(input int r);
        return (a.we0 && !m_null(int'(a.wa0)) && int'(a.wa0) == r) ||
               (a.we1 && !m_null(int'(a.wa1)) && int'(a.wa1) == r);
    endfunction

    function automatic logic [31:0] m_rd(input int r);
        if (m_null(r)) return 32'h0;
        if (a.we1 && int'(a.wa1) == r) return a.wd1;
        if (a.we0 && int'(a.wa0) == r) return a.wd0;
        return m_rf[r];
    endfunction

    function automatic bit m_rbusy(input int r);
        if (m_null(r) || m_writes(r)) return 1'b0;
        return m_busy[r];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREG; i++) begin
            m_rf[i]   = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one clock edge: weakest busy rule first so stronger ones overwrite it.
    task automatic m_edge();
        int w0 = int'(a.wa0);
        int w1 = int'(a.wa1);
        int ir = int'(a.iss_rd);
        if (a.we0 && !m_null(w0)) begin m_rf[w0] = a.wd0; m_busy[w0] = 1'b0; end
        if (a.we1 && !m_null(w1)) begin m_rf[w1] = a.wd1; m_busy[w1] = 1'b0; end
        if (a.iss_en && !m_null(ir)) m_busy[ir] = 1'b1;
        if (a.flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a.ra1 = '0; a.ra2 = '0;
        a.we0 = 1'b0; a.wa0 = '0; a.wd0 = '0;
        a.we1 = 1'b0; a.wa1 = '0; a.wd1 = '0;
        a.iss_en = 1'b0; a.iss_rd = '0; a.flush = 1'b0;
    endtask

    task automatic idle_b();
        b.ra1 = '0; b.ra2 = '0;
        b.we0 = 1'b0; b.wa0 = '0; b.wd0 = '0;
        b.we1 = 1'b0; b.wa1 = '0; b.wd1 = '0;
        b.iss_en = 1'b0; b.iss_rd = '0; b.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_a(); idle_b();
        rst = 1'b0;
        a.we0 = 1'b1; a.wa0 = 5'd3; a.wd0 = 32'hDEADBEEF; a.ra1 = 5'd3;
        repeat (3) tick();
        checks++;
        if (a.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_hold_cnt got=%0d exp=0", a.busy_cnt); end
        a.we0 = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (a.rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=00000000", a.rd1); end
        checks++;
        if (a.rbusy1 !== 1'b0) begin errors++; $display("FAIL reset_rbusy1 got=%b exp=0", a.rbusy1); end
        tick();
        checks++;
        if (a.rd1 !== 32'h0 || a.busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_after_edge rd1=%h cnt=%0d exp rd1=0 cnt=0", a.rd1, a.busy_cnt);
        end
        checks++;
        if (b.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_b_cnt got=%0d exp=0", b.busy_cnt); end
        $display("reset: released, rd1(r3)=%h busy_cnt=%0d", a.rd1, a.busy_cnt);
    endtask

    task automatic test_bypass();
        idle_a();
        a.we0 = 1'b1; a.wa0 = 5'd5; a.wd0 = 32'h11;
        a.we1 = 1'b1; a.wa1 = 5'd5; a.wd1 = 32'h22;
        a.ra1 = 5'd5; a.ra2 = 5'd5;
        #1;
        checks++;
        if (a.rd1 !== 32'h22) begin errors++; $display("FAIL bypass_p1_rd1 got=%h exp=00000022", a.rd1); end
        checks++;
        if (a.rd2 !== 32'h22) begin errors++; $display("FAIL bypass_p1_rd2 got=%h exp=00000022", a.rd2); end
        tick();
        idle_a();
        a.ra1 = 5'd5;
        a.we0 = 1'b1; a.wa0 = 5'd6; a.wd0 = 32'h33; a.ra2 = 5'd6;
        #1;
        checks++;
        if (a.rd1 !== 32'h22) begin errors++; $display("FAIL bypass_stored got=%h exp=00000022", a.rd1); end
        checks++;
        if (a.rd2 !== 32'h33) begin errors++; $display("FAIL bypass_p0_rd2 got=%h exp=00000033", a.rd2); end
        tick();
        idle_a();
        $display("bypass: r5 both ports -> %h, r6 port0 -> %h", 32'h22, 32'h33);
    endtask

    task automatic test_zero_reg();
        idle_a();
        a.we0 = 1'b1; a.wa0 = 5'd0; a.wd0 = 32'hFFFF_FFFF;
        a.iss_en = 1'b1; a.iss_rd = 5'd0; a.ra1 = 5'd0;
        #1;
        checks++;
        if (a.rd1 !== 32'h0) begin errors++; $display("FAIL zero_bypass got=%h exp=00000000", a.rd1); end
        tick();
        idle_a();
        #1;
        checks++;
        if (a.rd1 !== 32'h0 || a.rbusy1 !== 1'b0) begin
            errors++; $display("FAIL zero_stored rd1=%h rbusy1=%b exp 0/0", a.rd1, a.rbusy1);
        end
        checks++;
        if (a.busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt got=%0d exp=0", a.busy_cnt); end
        $display("zero_reg: write+issue r0 ignored, busy_cnt=%0d", a.busy_cnt);
    endtask

    task automatic test_scoreboard();
        idle_a();
        a.iss_en = 1'b1; a.iss_rd = 5'd7; a.ra1 = 5'd7;
        #1;
        checks++;
        if (a.rbusy1 !== 1'b0) begin errors++; $display("FAIL sb_own_dest got=%b exp=0", a.rbusy1); end
        tick();
        idle_a(); a.ra1 = 5'd7;
        #1;
        checks++;
        if (a.rbusy1 !== 1'b1 || a.busy_cnt !== 6'd1) begin
            errors++; $display("FAIL sb_issue rbusy1=%b cnt=%0d exp 1/1", a.rbusy1, a.busy_cnt);
        end
        a.we1 = 1'b1; a.wa1 = 5'd7; a.wd1 = 32'h77;
        #1;
        checks++;
        if (a.rbusy1 !== 1'b0 || a.rd1 !== 32'h77) begin
            errors++; $display("FAIL sb_write_clear rbusy1=%b rd1=%h exp 0/00000077", a.rbusy1, a.rd1);
        end
        tick();
        idle_a(); a.ra1 = 5'd7;
        #1;
        checks++;
        if (a.busy_cnt !== 6'd0) begin errors++; $display("FAIL sb_cnt_clear got=%0d exp=0", a.busy_cnt); end
        a.iss_en = 1'b1; a.iss_rd = 5'd7;
        a.we0 = 1'b1; a.wa0 = 5'd7; a.wd0 = 32'h78;
        tick();
        idle_a(); a.ra1 = 5'd7;
        #1;
        checks++;
        if (a.rbusy1 !== 1'b1 || a.busy_cnt !== 6'd1 || a.rd1 !== 32'h78) begin
            errors++; $display("FAIL sb_issue_write rbusy1=%b cnt=%0d rd1=%h exp 1/1/00000078",
                               a.rbusy1, a.busy_cnt, a.rd1);
        end
        a.we0 = 1'b1; a.wa0 = 5'd7; a.wd0 = 32'h79;
        tick();
        idle_a();
        $display("scoreboard: r7 issue/write sequence done, busy_cnt=%0d", a.busy_cnt);
    endtask

    task automatic test_flush();
        idle_a();
        for (int r = 1; r <= 3; r++) begin
            a.iss_en = 1'b1; a.iss_rd = AW'(r);
            tick();
        end
        idle_a(); a.ra1 = 5'd2;
        #1;
        checks++;
        if (a.busy_cnt !== 6'd3 || a.rbusy1 !== 1'b1) begin
            errors++; $display("FAIL flush_pre cnt=%0d rbusy1=%b exp 3/1", a.busy_cnt, a.rbusy1);
        end
        a.flush = 1'b1; a.iss_en = 1'b1; a.iss_rd = 5'd4;
        a.we0 = 1'b1; a.wa0 = 5'd1; a.wd0 = 32'hF1;
        tick();
        idle_a(); a.ra1 = 5'd4; a.ra2 = 5'd1;
        #1;
        checks++;
        if (a.busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", a.busy_cnt); end
        checks++;
        if (a.rbusy1 !== 1'b0 || a.rbusy2 !== 1'b0) begin
            errors++; $display("FAIL flush_rbusy got=%b%b exp=00", a.rbusy1, a.rbusy2);
        end
        checks++;
        if (a.rd2 !== 32'hF1) begin errors++; $display("FAIL flush_write got=%h exp=000000f1", a.rd2); end
        a.ra1 = 5'd3;
        #1;
        checks++;
        if (a.rbusy1 !== 1'b0) begin errors++; $display("FAIL flush_r3 got=%b exp=0", a.rbusy1); end
        $display("flush: r1..r3 cleared, issue r4 suppressed, busy_cnt=%0d", a.busy_cnt);
    endtask

    task automatic test_nonpow2();
        idle_b();
        b.we0 = 1'b1; b.wa0 = 5'd30; b.wd0 = 32'h55; b.ra1 = 5'd30;
        #1;
        checks++;
        if (b.rd1 !== 32'h0) begin errors++; $display("FAIL np2_oob_bypass got=%h exp=00000000", b.rd1); end
        tick();
        idle_b(); b.ra1 = 5'd30;
        #1;
        checks++;
        if (b.rd1 !== 32'h0) begin errors++; $display("FAIL np2_oob_stored got=%h exp=00000000", b.rd1); end
        b.we0 = 1'b1; b.wa0 = 5'd23; b.wd0 = 32'hA5;
        b.iss_en = 1'b1; b.iss_rd = 5'd25;
        tick();
        idle_b(); b.ra1 = 5'd23;
        #1;
        checks++;
        if (b.rd1 !== 32'hA5) begin errors++; $display("FAIL np2_top_reg got=%h exp=000000a5", b.rd1); end
        checks++;
        if (b.busy_cnt !== 6'd0) begin errors++; $display("FAIL np2_oob_issue got=%0d exp=0", b.busy_cnt); end
        b.iss_en = 1'b1; b.iss_rd = 5'd23;
        tick();
        idle_b(); b.ra2 = 5'd23;
        #1;
        checks++;
        if (b.busy_cnt !== 6'd1 || b.rbusy2 !== 1'b1) begin
            errors++; $display("FAIL np2_issue_top cnt=%0d rbusy2=%b exp 1/1", b.busy_cnt, b.rbusy2);
        end
        $display("nonpow2: r30 ignored, r23=%h busy_cnt=%0d", b.rd1, b.busy_cnt);
    endtask

    task automatic test_reset_mid();
        idle_a();
        a.we1 = 1'b1; a.wa1 = 5'd9; a.wd1 = 32'h9999;
        a.iss_en = 1'b1; a.iss_rd = 5'd10;
        tick();
        idle_a();
        a.we0 = 1'b1; a.wa0 = 5'd11; a.wd0 = 32'hBAD;
        #2;
        rst = 1'b0;
        a.ra1 = 5'd9; a.ra2 = 5'd11;
        #1;
        checks++;
        if (a.rd1 !== 32'h0 || a.rd2 !== 32'h0) begin
            errors++; $display("FAIL midrst_data rd1=%h rd2=%h exp 0/0", a.rd1, a.rd2);
        end
        checks++;
        if (a.busy_cnt !== 6'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", a.busy_cnt); end
        idle_a();
        m_clear();
        tick();
        rst = 1'b1;
        $display("reset_mid: async reset cleared data and scoreboard");
    endtask

    task automatic test_random();
        int ad;
        for (int n = 0; n < 200; n++) begin
            a.we0 = 1'($urandom_range(0, 1));
            a.we1 = 1'($urandom_range(0, 1));
            a.iss_en = 1'($urandom_range(0, 1));
            a.flush = ($urandom_range(0, 19) == 0);
            a.wd0 = $urandom; a.wd1 = $urandom;
            ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7); a.wa0 = AW'(ad);
            ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7); a.wa1 = AW'(ad);
            ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7); a.iss_rd = AW'(ad);
            ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7); a.ra1 = AW'(ad);
            ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7); a.ra2 = AW'(ad);
            #1;
            checks++;
            if (a.rd1 !== m_rd(int'(a.ra1)) || a.rd2 !== m_rd(int'(a.ra2))) begin
                errors++;
                $display("FAIL rand_rd cyc=%0d got=%h/%h exp=%h/%h", n, a.rd1, a.rd2,
                         m_rd(int'(a.ra1)), m_rd(int'(a.ra2)));
            end
            checks++;
            if (a.rbusy1 !== m_rbusy(int'(a.ra1)) || a.rbusy2 !== m_rbusy(int'(a.ra2))) begin
                errors++;
                $display("FAIL rand_rbusy cyc=%0d got=%b%b exp=%b%b", n, a.rbusy1, a.rbusy2,
                         m_rbusy(int'(a.ra1)), m_rbusy(int'(a.ra2)));
            end
            tick();
            m_edge();
            checks++;
            if (int'(a.busy_cnt) != m_count()) begin
                errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", n, a.busy_cnt, m_count());
            end
            $display("rand %0d: w0=%b@%0d w1=%b@%0d iss=%b@%0d fl=%b cnt=%0d", n, a.we0, a.wa0,
                     a.we1, a.wa1, a.iss_en, a.iss_rd, a.flush, a.busy_cnt);
        end
        idle_a();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_nonpow2();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
